// File: rtl/ram_burst_ctrl.sv
// Single-port word RAM with write/read/burst-read/clear commands and self-zeroing after reset.
// Optional per-word even parity is enabled by defining RAM_PARITY_EN.
module ram_burst_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // Command handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both 1;
    // read beats have no backpressure and must be sampled on every rd_valid cycle.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              par_inject,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              par_err,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_BURST = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_BURST = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                par_err_q, par_err_d;

    logic [DATA_W-1:0]   mem_q [2**ADDR_W];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   mem_rdata;
    logic                rd_perr;

    assign mem_rdata = mem_q[rd_addr];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_data_d  = rd_data_q;
        par_err_d  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr_q;
        mem_wdata  = '0;
        rd_addr    = addr_q;
        case (state_q)
            S_INIT, S_CLEAR: begin
                mem_we = 1'b1;
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                rd_addr = cmd_addr;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            mem_we    = 1'b1;
                            mem_waddr = cmd_addr;
                            mem_wdata = cmd_wdata;
                        end
                        OP_READ, OP_BURST: begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = mem_rdata;
                            par_err_d  = rd_perr;
                            rd_last_d  = (cmd_op == OP_READ) || (cmd_len == '0);
                            // A zero-length burst is a plain read and never leaves IDLE.
                            if (cmd_op == OP_BURST && cmd_len != '0) begin
                                state_d = S_BURST;
                                addr_d  = cmd_addr + ADDR_W'(1);
                                rem_d   = cmd_len;
                            end
                        end
                        default: begin
                            state_d = S_CLEAR;
                            addr_d  = '0;
                        end
                    endcase
                end
            end
            default: begin
                // rem_q counts beats still owed; BURST lasts through the final beat cycle.
                if (rem_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem_rdata;
                    par_err_d  = rd_perr;
                    rd_last_d  = (rem_q == ADDR_W'(1));
                    addr_d     = addr_q + ADDR_W'(1);
                    rem_d      = rem_q - ADDR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            addr_q     <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
            par_err_q  <= par_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

`ifdef RAM_PARITY_EN
    logic [2**ADDR_W-1:0] par_q;
    logic                 mem_winv;

    assign mem_winv = (state_q == S_IDLE) && cmd_valid && (cmd_op == OP_WRITE) && par_inject;
    assign rd_perr  = (^mem_rdata) ^ par_q[rd_addr];

    always_ff @(posedge clk) begin
        if (mem_we) par_q[mem_waddr] <= (^mem_wdata) ^ mem_winv;
    end
`else
    logic unused_par_inject;
    assign unused_par_inject = par_inject;
    assign rd_perr           = 1'b0;
`endif

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign rd_data     = rd_data_q;
    assign par_err     = par_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl (DATA_W=8, ADDR_W=4): reset/INIT, read/write, bursts, clear, parity.
module tb_ram_burst_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] cmd_wdata;
    logic       par_inject;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       par_err;
    logic       busy;
    logic [1:0] dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [10:0] beat;
    logic [10:0] exp_beat;
    logic        exp_perr;

    ram_burst_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_wdata   (cmd_wdata),
        .par_inject  (par_inject),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .par_err     (par_err),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command, waiting a bounded time for cmd_ready, then drops cmd_valid.
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [3:0] len,
                            input logic [7:0] wdata, input logic inj);
        int k;
        cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_wdata = wdata; par_inject = inj;
        cmd_valid = 1'b1;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait op=%0d act=%b exp=1", op, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        par_inject = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({busy, cmd_ready, rd_valid, rd_last, par_err, rd_data} !== {5'b10000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_outputs act=%b exp=%b",
                     {busy, cmd_ready, rd_valid, rd_last, par_err, rd_data}, {5'b10000, 8'h00});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if ({busy, cmd_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL init_busy cycle=%0d act=%b exp=10", i, {busy, cmd_ready});
            end
            tick();
        end
        n_cmp++;
        if ({busy, cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL init_done act=%b exp=01", {busy, cmd_ready});
        end
        send_cmd(2'b01, 4'd5, 4'd0, 8'h00, 1'b0);
        beat = {rd_valid, rd_last, par_err, rd_data};
        n_cmp++;
        if (beat !== 11'b110_0000_0000) begin
            n_fail++;
            $display("FAIL init_read5 act=%h exp=%h", beat, 11'b110_0000_0000);
        end
        tick();
        n_cmp++;
        if ({rd_valid, rd_last} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_beat act=%b exp=00", {rd_valid, rd_last});
        end
    endtask

    task automatic test_write_read();
        send_cmd(2'b00, 4'd3, 4'd0, 8'hA5, 1'b0);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_beat act=%b exp=0", rd_valid);
        end
        send_cmd(2'b01, 4'd3, 4'd0, 8'h00, 1'b0);
        beat = {rd_valid, rd_last, par_err, rd_data};
        exp_beat = {3'b110, 8'hA5};
        n_cmp++;
        if (beat !== exp_beat) begin
            n_fail++;
            $display("FAIL write_read3 act=%h exp=%h", beat, exp_beat);
        end
    endtask

    task automatic test_back_to_back();
        send_cmd(2'b00, 4'd4, 4'd0, 8'h5A, 1'b0);
        send_cmd(2'b00, 4'd9, 4'd0, 8'hC3, 1'b0);
        send_cmd(2'b01, 4'd3, 4'd0, 8'h00, 1'b0);
        exp_beat = {3'b110, 8'hA5};
        n_cmp++;
        if ({rd_valid, rd_last, par_err, rd_data} !== exp_beat) begin
            n_fail++;
            $display("FAIL b2b_read3 act=%h exp=%h", {rd_valid, rd_last, par_err, rd_data}, exp_beat);
        end
        send_cmd(2'b01, 4'd4, 4'd0, 8'h00, 1'b0);
        exp_beat = {3'b110, 8'h5A};
        n_cmp++;
        if ({rd_valid, rd_last, par_err, rd_data} !== exp_beat) begin
            n_fail++;
            $display("FAIL b2b_read4 act=%h exp=%h", {rd_valid, rd_last, par_err, rd_data}, exp_beat);
        end
        send_cmd(2'b01, 4'd9, 4'd0, 8'h00, 1'b0);
        exp_beat = {3'b110, 8'hC3};
        n_cmp++;
        if ({rd_valid, rd_last, par_err, rd_data} !== exp_beat) begin
            n_fail++;
            $display("FAIL b2b_read9 act=%h exp=%h", {rd_valid, rd_last, par_err, rd_data}, exp_beat);
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_data [3];
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
        send_cmd(2'b00, 4'd14, 4'd0, 8'h11, 1'b0);
        send_cmd(2'b00, 4'd15, 4'd0, 8'h22, 1'b0);
        send_cmd(2'b00, 4'd0,  4'd0, 8'h33, 1'b0);
        send_cmd(2'b10, 4'd14, 4'd2, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_beat = {1'b1, (i == 2), 1'b0, exp_data[i]};
            n_cmp++;
            if ({rd_valid, rd_last, par_err, rd_data} !== exp_beat || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL burst_beat%0d act=%h rdy=%b exp=%h rdy=0", i,
                         {rd_valid, rd_last, par_err, rd_data}, cmd_ready, exp_beat);
            end
            tick();
        end
        n_cmp++;
        if ({cmd_ready, busy, rd_valid, rd_last, rd_data} !== {4'b1000, 8'h33}) begin
            n_fail++;
            $display("FAIL burst_end act=%b exp=%b", {cmd_ready, busy, rd_valid, rd_last, rd_data},
                     {4'b1000, 8'h33});
        end
    endtask

    task automatic test_burst_len0();
        send_cmd(2'b10, 4'd3, 4'd0, 8'h00, 1'b0);
        exp_beat = {3'b110, 8'hA5};
        n_cmp++;
        if ({rd_valid, rd_last, par_err, rd_data} !== exp_beat) begin
            n_fail++;
            $display("FAIL burst_len0 act=%h exp=%h", {rd_valid, rd_last, par_err, rd_data}, exp_beat);
        end
        tick();
        n_cmp++;
        if ({rd_valid, cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL burst_len0_after act=%b exp=01", {rd_valid, cmd_ready});
        end
    endtask

    task automatic test_reset_mid_burst();
        send_cmd(2'b10, 4'd14, 4'd2, 8'h00, 1'b0);
        tick();
        exp_beat = {3'b100, 8'h22};
        n_cmp++;
        if ({rd_valid, rd_last, par_err, rd_data} !== exp_beat) begin
            n_fail++;
            $display("FAIL rst_burst_beat1 act=%h exp=%h", {rd_valid, rd_last, par_err, rd_data}, exp_beat);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rd_valid, rd_last, busy, cmd_ready, rd_data} !== {4'b0010, 8'h00}) begin
            n_fail++;
            $display("FAIL rst_mid_burst act=%b exp=%b", {rd_valid, rd_last, busy, cmd_ready, rd_data},
                     {4'b0010, 8'h00});
        end
        repeat (3) tick();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_beats act=%b exp=0", rd_valid);
        end
        rst_n = 1'b1;
        send_cmd(2'b10, 4'd14, 4'd2, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_beat = {1'b1, (i == 2), 1'b0, 8'h00};
            n_cmp++;
            if ({rd_valid, rd_last, par_err, rd_data} !== exp_beat) begin
                n_fail++;
                $display("FAIL post_init_beat%0d act=%h exp=%h", i,
                         {rd_valid, rd_last, par_err, rd_data}, exp_beat);
            end
            tick();
        end
    endtask

    task automatic test_clear();
        send_cmd(2'b00, 4'd7, 4'd0, 8'hFF, 1'b0);
        send_cmd(2'b11, 4'd0, 4'd0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if ({busy, cmd_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL clear_busy cycle=%0d act=%b exp=10", i, {busy, cmd_ready});
            end
            tick();
        end
        n_cmp++;
        if ({busy, cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL clear_done act=%b exp=01", {busy, cmd_ready});
        end
        send_cmd(2'b01, 4'd7, 4'd0, 8'h00, 1'b0);
        exp_beat = {3'b110, 8'h00};
        n_cmp++;
        if ({rd_valid, rd_last, par_err, rd_data} !== exp_beat) begin
            n_fail++;
            $display("FAIL clear_read7 act=%h exp=%h", {rd_valid, rd_last, par_err, rd_data}, exp_beat);
        end
    endtask

    task automatic test_parity();
`ifdef RAM_PARITY_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        send_cmd(2'b00, 4'd2, 4'd0, 8'h0F, 1'b1);
        send_cmd(2'b00, 4'd6, 4'd0, 8'h07, 1'b0);
        send_cmd(2'b01, 4'd2, 4'd0, 8'h00, 1'b0);
        exp_beat = {2'b11, exp_perr, 8'h0F};
        n_cmp++;
        if ({rd_valid, rd_last, par_err, rd_data} !== exp_beat) begin
            n_fail++;
            $display("FAIL parity_inject act=%h exp=%h", {rd_valid, rd_last, par_err, rd_data}, exp_beat);
        end
        send_cmd(2'b01, 4'd6, 4'd0, 8'h00, 1'b0);
        exp_beat = {3'b110, 8'h07};
        n_cmp++;
        if ({rd_valid, rd_last, par_err, rd_data} !== exp_beat) begin
            n_fail++;
            $display("FAIL parity_clean act=%h exp=%h", {rd_valid, rd_last, par_err, rd_data}, exp_beat);
        end
        tick();
        n_cmp++;
        if ({rd_valid, par_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL parity_idle act=%b exp=00", {rd_valid, par_err});
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0;
        cmd_len = '0; cmd_wdata = '0; par_inject = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_burst();
        test_burst_len0();
        test_reset_mid_burst();
        test_clear();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; depth = 2^ADDR_W words.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at an edge.
REQ-007 SHALL have port cmd_op  input  2  00 write, 01 read, 10 burst read, 11 clear.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  word address or burst start address.
REQ-009 SHALL have port cmd_len  input  ADDR_W  burst beats minus one (burst read only).
REQ-010 SHALL have port cmd_wdata  input  DATA_W  write data.
REQ-011 SHALL have port par_inject  input  1  store inverted parity on write (RAM_PARITY_EN only).
REQ-012 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-013 SHALL have port rd_data  output  DATA_W  read data.
REQ-014 SHALL have port rd_last  output  1  final beat of a read or burst.
REQ-015 SHALL have port par_err  output  1  parity mismatch on current beat.
REQ-016 SHALL have port busy  output  1  FSM outside IDLE.

Function
REQ-017 SHALL implement FSM states INIT, IDLE, BURST, CLEAR; cmd_ready = 1 only in IDLE.
REQ-018 INIT SHALL write 0 to addresses 0..2^ADDR_W-1, one per cycle ascending, then enter IDLE.
REQ-019 Accepted write SHALL update memory at the accepting edge; FSM stays IDLE, cmd_ready stays 1 (back-to-back writes allowed).
REQ-020 Accepted read SHALL produce rd_valid=1, rd_last=1, rd_data=mem[addr] in the next cycle; back-to-back reads SHALL be accepted every cycle.
REQ-021 Read accepted the cycle after a write to the same address SHALL return the new data.
REQ-022 Accepted burst SHALL enter BURST and emit cmd_len+1 beats on consecutive cycles starting the next cycle, addresses cmd_addr+i modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0).
REQ-023 rd_last SHALL be 1 only on the final burst beat; FSM returns to IDLE so cmd_ready=1 the cycle after the final beat.
REQ-024 cmd_len=0 burst SHALL behave as a single read with rd_last=1.
REQ-025 Accepted clear SHALL enter CLEAR, zero all words in 2^ADDR_W cycles exactly as INIT, then IDLE.
REQ-026 rd_valid, rd_last, par_err SHALL be 0 whenever no beat is presented; rd_data holds last value.
REQ-027 No read backpressure; consumers SHALL sample every rd_valid cycle.

Reset
REQ-028 rst_n low SHALL immediately force state INIT, address counter 0, cmd_ready 0, busy 1, rd_valid 0, rd_last 0, rd_data 0, par_err 0.
REQ-029 Reset mid-burst or mid-clear SHALL abort the operation; no further beats emitted.
REQ-030 Memory array SHALL have no reset; contents are zeroed by INIT after rst_n rises.

Configuration
REQ-031 With macro RAM_PARITY_EN defined, each word SHALL store an even-parity bit (inverted when par_inject=1 at write); par_err=1 on a beat whose recomputed parity mismatches; INIT/CLEAR store correct parity.
REQ-032 Without RAM_PARITY_EN, no parity storage SHALL exist, par_inject SHALL be ignored, par_err SHALL be constant 0.

Verification (DATA_W=8, ADDR_W=4)
REQ-033 Release rst_n -> busy=1, cmd_ready=0 for 16 cycles, then cmd_ready=1; read addr 5 -> rd_data 0x00.
REQ-034 Write 0xA5 @3, read @3 next cycle -> one cycle later rd_valid=1, rd_data=0xA5, rd_last=1.
REQ-035 Write 0x11@14, 0x22@15, 0x33@0; burst addr 14 len 2 -> beats 0x11, 0x22, 0x33 on consecutive cycles, rd_last on third, cmd_ready=1 following cycle.
REQ-036 Assert rst_n low during second beat of REQ-035 burst -> rd_valid=0 immediately; after INIT, burst @14 len 2 returns 0x00 x3.
REQ-037 Write 0xFF@7, clear -> busy=1 for 16 cycles; read @7 returns 0x00.
REQ-038 RAM_PARITY_EN: write 0x0F @2 with par_inject=1, read @2 -> par_err=1; without macro -> par_err=0.
